// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the OpenRAM RW port between two requesters.
// Every macro-facing signal is registered; each access is a grant/issue/response sequence.

module sram_rw_port_arbiter_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ack_set,
  input  logic                  rd_load,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= ack_set;
      if (rd_load) rdata <= dout;
    end
  end
endmodule

module sram_rw_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  req_t [NUM_REQ-1:0]                 rq;
  logic [NUM_REQ-1:0]                 req_v, ack_v, elig, rsp_ld;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_v;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;   // 1 = B
  logic                  last_q, last_d; // 1 = B
  logic                  we_q, we_d;
  logic                  gnt;
  logic                  csb_d, web_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;

  assign rq[0]  = {a_we, a_wmask, a_addr, a_wdata};
  assign rq[1]  = {b_we, b_wmask, b_addr, b_wdata};
  assign req_v  = {b_req, a_req};
  // Masking with ack stops a requester from re-winning in the cycle it drops req.
  assign elig   = req_v & ~ack_v;
  assign gnt    = elig[1] & (~elig[0] | ~last_q);
  assign rsp_ld = {(state_q == RESP) & sel_q, (state_q == RESP) & ~sel_q};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    we_d    = we_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = sram_addr0;
    din_d   = sram_din0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          sel_d   = gnt;
          last_d  = gnt;
          we_d    = rq[gnt].we;
          csb_d   = 1'b0;
          web_d   = ~rq[gnt].we;
          wmask_d = rq[gnt].wmask;
          addr_d  = rq[gnt].addr;
          din_d   = rq[gnt].wdata;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      we_q        <= we_d;
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
    end
  end

  // Macro drives dout after the negedge of the issue cycle, so it is stable here.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sram_rw_port_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ack_set (rsp_ld[i]),
      .rd_load (rsp_ld[i] & ~we_q),
      .dout    (sram_dout0),
      .ack     (ack_v[i]),
      .rdata   (rdata_v[i])
    );
  end

  assign a_ack   = ack_v[0];
  assign b_ack   = ack_v[1];
  assign a_rdata = rdata_v[0];
  assign b_rdata = rdata_v[1];
endmodule
